// File: rtl/pe_pkg.sv
// Shared types, default widths and the saturating adder for the PE array.
package pe_pkg;

  localparam int unsigned A_W_DEF   = 8;
  localparam int unsigned W_W_DEF   = 8;
  localparam int unsigned ACC_W_DEF = 32;
  localparam int unsigned SKIP_W    = 16;
  localparam int unsigned SAT_MAX_W = 64;

  // Per-PE control word driven by the array controller
  typedef struct packed {
    logic en;
    logic clr;
    logic w_load;
    logic w_swap;
  } pe_ctrl_t;

  // Adder result: overflow indication plus the width-adjusted sum
  typedef struct packed {
    logic                        ovf;
    logic signed [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Add two w-bit signed values (sign-extended to SAT_MAX_W) at w+1 bits;
  // clamp to the signed w-bit range when sat is set, otherwise wrap.
  function automatic sat_res_t sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int unsigned                 w,
    input logic                        sat
  );
    logic signed [SAT_MAX_W:0] s;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    logic signed [SAT_MAX_W:0] wrap;
    int unsigned               sh;
    sat_res_t                  r;
    s    = (SAT_MAX_W+1)'(a) + (SAT_MAX_W+1)'(b);
    hi   = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
    lo   = ~hi;
    sh   = SAT_MAX_W + 1 - w;
    wrap = (s <<< sh) >>> sh;
    r.ovf = (s > hi) || (s < lo);
    if (sat && (s > hi)) begin
      r.sum = SAT_MAX_W'(hi);
    end else if (sat && (s < lo)) begin
      r.sum = SAT_MAX_W'(lo);
    end else begin
      r.sum = SAT_MAX_W'(wrap);
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_ws_db_wbuf.sv
// Double-buffered weight store: shadow register, active weight, swap error.
module pe_wbuf
  import pe_pkg::*;
#(
  parameter int unsigned W_W = W_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W_W-1:0] w_in,
  input  logic           w_load,
  input  logic           w_swap,
  output logic [W_W-1:0] w_act,
  output logic           shadow_vld,
  output logic           swap_err
);

  logic [W_W-1:0] w_shadow;

  // Load into shadow, promote on swap; a swap with an empty shadow is an error
  always_ff @(posedge clk) begin
    if (rst) begin
      w_act      <= '0;
      w_shadow   <= '0;
      shadow_vld <= 1'b0;
      swap_err   <= 1'b0;
    end else begin
      if (w_swap && shadow_vld) begin
        w_act <= w_shadow;
      end
      if (w_swap && !shadow_vld) begin
        swap_err <= 1'b1;
      end
      if (w_load) begin
        w_shadow   <= w_in;
        shadow_vld <= 1'b1;
      end else if (w_swap) begin
        shadow_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe_ws_db.sv
// Weight-stationary PE with double-buffered weights and saturating MAC.
// Optional build macro PE_ZERO_SKIP_EN gates the accumulator on zero
// operands and adds the skip_cnt output.
module pe_ws_db
  import pe_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned W_W   = W_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned SAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [A_W-1:0]   a_in,
  input  logic             a_vld_in,
  output logic [A_W-1:0]   a_out,
  output logic             a_vld_out,
  input  logic [W_W-1:0]   w_in,
  input  logic             w_load,
  input  logic             w_swap,
  input  logic             en,
  input  logic             clr,
  output logic [ACC_W-1:0] acc,
  output logic             shadow_vld,
  output logic             sat_flag,
  output logic             swap_err
`ifdef PE_ZERO_SKIP_EN
  ,
  output logic [SKIP_W-1:0] skip_cnt
`endif
);

  localparam int unsigned PROD_W = A_W + W_W;

  logic [W_W-1:0]              w_act;
  logic                        mac;
  logic                        acc_upd;
  logic signed [PROD_W-1:0]    prod;
  logic signed [SAT_MAX_W-1:0] base_x;
  logic signed [SAT_MAX_W-1:0] prod_x;
  sat_res_t                    add_r;
  logic                        unused_sum_hi;

  pe_wbuf #(.W_W(W_W)) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .w_in       (w_in),
    .w_load     (w_load),
    .w_swap     (w_swap),
    .w_act      (w_act),
    .shadow_vld (shadow_vld),
    .swap_err   (swap_err)
  );

`ifdef PE_ZERO_SKIP_EN
  logic skip;
  // A zero operand contributes nothing, so the accumulator write is skipped
  always_comb begin
    skip = mac & ~clr & ((a_in == '0) | (w_act == '0));
  end
`endif

  // Product and sum; clr restarts the sum from zero
  always_comb begin
    mac     = en & a_vld_in;
`ifdef PE_ZERO_SKIP_EN
    acc_upd = mac & ~skip;
`else
    acc_upd = mac;
`endif
    prod    = PROD_W'($signed(a_in)) * PROD_W'($signed(w_act));
    base_x  = clr ? '0 : SAT_MAX_W'($signed(acc));
    prod_x  = SAT_MAX_W'(prod);
    add_r   = sat_add(base_x, prod_x, ACC_W, SAT != 0);
  end

  assign unused_sum_hi = ^add_r.sum[SAT_MAX_W-1:ACC_W];

  // Accumulator and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (clr) begin
      if (mac) begin
        acc      <= add_r.sum[ACC_W-1:0];
        sat_flag <= add_r.ovf;
      end else begin
        acc      <= '0;
        sat_flag <= 1'b0;
      end
    end else if (acc_upd) begin
      acc      <= add_r.sum[ACC_W-1:0];
      sat_flag <= sat_flag | add_r.ovf;
    end
  end

`ifdef PE_ZERO_SKIP_EN
  // Saturating count of gated-off MACs since the last clear
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      skip_cnt <= '0;
    end else if (skip && (skip_cnt != '1)) begin
      skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end
`endif

  generate
    if (PIPE != 0) begin : g_fwd_reg
      // Registered activation forward to the right neighbour
      always_ff @(posedge clk) begin
        if (rst) begin
          a_out     <= '0;
          a_vld_out <= 1'b0;
        end else begin
          a_out     <= a_in;
          a_vld_out <= a_vld_in;
        end
      end
    end else begin : g_fwd_comb
      // Combinational activation forward
      always_comb begin
        a_out     = a_in;
        a_vld_out = a_vld_in;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pe_ws_db.sv
// Scoreboard bench for pe_ws_db (ACC_W=16, PIPE=1, SAT=1).
module tb_pe_ws_db;

  localparam int unsigned A_W   = 8;
  localparam int unsigned W_W   = 8;
  localparam int unsigned ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [A_W-1:0]   a_in = '0;
  logic             a_vld_in = 1'b0;
  logic [A_W-1:0]   a_out;
  logic             a_vld_out;
  logic [W_W-1:0]   w_in = '0;
  logic             w_load = 1'b0;
  logic             w_swap = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [ACC_W-1:0] acc;
  logic             shadow_vld;
  logic             sat_flag;
  logic             swap_err;
`ifdef PE_ZERO_SKIP_EN
  logic [15:0]      skip_cnt;
`endif

  pe_ws_db #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W), .PIPE(1), .SAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .a_vld_in   (a_vld_in),
    .a_out      (a_out),
    .a_vld_out  (a_vld_out),
    .w_in       (w_in),
    .w_load     (w_load),
    .w_swap     (w_swap),
    .en         (en),
    .clr        (clr),
    .acc        (acc),
    .shadow_vld (shadow_vld),
    .sat_flag   (sat_flag),
    .swap_err   (swap_err)
`ifdef PE_ZERO_SKIP_EN
    ,
    .skip_cnt   (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    bit sat;
    bit shv;
    bit serr;
    int aout;
    bit avo;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("acc",        32'($signed(acc)),   e.acc);
        chk("sat_flag",   32'(sat_flag),       int'(e.sat));
        chk("shadow_vld", 32'(shadow_vld),     int'(e.shv));
        chk("swap_err",   32'(swap_err),       int'(e.serr));
        chk("a_out",      32'($signed(a_out)), e.aout);
        chk("a_vld_out",  32'(a_vld_out),      int'(e.avo));
      end
    end
  end

  // One clock of stimulus plus the hand-computed state after its edge
  task automatic step(input bit r, input int a, input bit av, input bit e, input bit c,
                      input int w, input bit wl, input bit ws,
                      input int eacc, input bit esat, input bit eshv, input bit eserr);
    exp_t x;
    @(negedge clk);
    rst      = r;
    a_in     = A_W'(a);
    a_vld_in = av;
    en       = e;
    clr      = c;
    w_in     = W_W'(w);
    w_load   = wl;
    w_swap   = ws;
    x.acc  = eacc;
    x.sat  = esat;
    x.shv  = eshv;
    x.serr = eserr;
    x.aout = r ? 0 : a;
    x.avo  = r ? 1'b0 : av;
    q.push_back(x);
  endtask

  initial begin
    // args: rst, a, a_vld, en, clr, w, w_load, w_swap | acc, sat, shv, serr
    step(1,   0, 0, 0, 0,    0, 0, 0,      0, 0, 0, 0);
    step(1,   0, 0, 0, 0,    0, 0, 0,      0, 0, 0, 0);
    // swap on empty shadow, then load+swap on empty shadow
    step(0,   0, 0, 0, 0,    0, 0, 1,      0, 0, 0, 1);
    step(0,   0, 0, 0, 0,    7, 1, 1,      0, 0, 1, 1);
    step(0,   3, 1, 1, 0,    0, 0, 0,      0, 0, 1, 1);
    step(0,   0, 0, 0, 0,    0, 0, 1,      0, 0, 0, 1);
    step(0,   2, 1, 1, 0,    0, 0, 0,     14, 0, 0, 1);
    // load+swap with a full shadow
    step(0,   0, 0, 0, 0,    9, 1, 0,     14, 0, 1, 1);
    step(0,   0, 0, 0, 0,    4, 1, 1,     14, 0, 1, 1);
    step(0,   1, 1, 1, 0,    0, 0, 0,     23, 0, 1, 1);
    step(0,   0, 0, 0, 0,    0, 0, 1,     23, 0, 0, 1);
    step(0,   1, 1, 1, 0,    0, 0, 0,     27, 0, 0, 1);
    step(1,   0, 0, 0, 0,    0, 0, 0,      0, 0, 0, 0);
    // load 3, swap, MACs 1,2,4
    step(0,   0, 0, 0, 0,    3, 1, 0,      0, 0, 1, 0);
    step(0,   0, 0, 0, 0,    0, 0, 1,      0, 0, 0, 0);
    step(0,   1, 1, 1, 0,    0, 0, 0,      3, 0, 0, 0);
    step(0,   2, 1, 1, 0,    0, 0, 0,      9, 0, 0, 0);
    step(0,   4, 1, 1, 0,    0, 0, 0,     21, 0, 0, 0);
    // overlapped load and swap during MACs
    step(0,   2, 1, 1, 0,    5, 1, 0,     27, 0, 1, 0);
    step(0,   2, 1, 1, 0,    0, 0, 1,     33, 0, 0, 0);
    step(0,   2, 1, 1, 0,    0, 0, 0,     43, 0, 0, 0);
    // activation forward, independent of en; en without valid holds acc
    step(0,   9, 1, 0, 0,    0, 0, 0,     43, 0, 0, 0);
    step(0,  77, 0, 0, 0,    0, 0, 0,     43, 0, 0, 0);
    step(0,  -4, 1, 0, 0,    0, 0, 0,     43, 0, 0, 0);
    step(0,   5, 0, 1, 0,    0, 0, 0,     43, 0, 0, 0);
    // back-to-back loads: last one wins
    step(0,   0, 0, 0, 0,    6, 1, 0,     43, 0, 1, 0);
    step(0,   0, 0, 0, 0,   -2, 1, 0,     43, 0, 1, 0);
    step(0,   0, 0, 0, 0,    0, 0, 1,     43, 0, 0, 0);
    step(0,   3, 1, 1, 0,    0, 0, 0,     37, 0, 0, 0);
    // reset mid-stream
    step(1,   2, 1, 1, 0,    0, 0, 0,      0, 0, 0, 0);
    // positive saturation to 32767, sticky, then clr&mac
    step(0,   0, 0, 0, 0,  120, 1, 0,      0, 0, 1, 0);
    step(0,   0, 0, 0, 0,    0, 0, 1,      0, 0, 0, 0);
    step(0, 120, 1, 1, 1,    0, 0, 0,  14400, 0, 0, 0);
    step(0, 120, 1, 1, 0,    0, 0, 0,  28800, 0, 0, 0);
    step(0,  33, 1, 1, 0,  127, 1, 0,  32760, 0, 1, 0);
    step(0,   0, 0, 0, 0,    0, 0, 1,  32760, 0, 0, 0);
    step(0, 127, 1, 1, 0,    1, 1, 0,  32767, 1, 1, 0);
    step(0,  -1, 1, 1, 0,    0, 0, 1,  32640, 1, 0, 0);
    step(0,   1, 1, 1, 1,    0, 0, 0,      1, 0, 0, 0);
    // negative saturation to -32768, then plain clr
    step(0,   0, 0, 0, 0, -128, 1, 0,      1, 0, 1, 0);
    step(0,   0, 0, 0, 1,    0, 0, 1,      0, 0, 0, 0);
    step(0, 127, 1, 1, 0,    0, 0, 0, -16256, 0, 0, 0);
    step(0, 127, 1, 1, 0,    0, 0, 0, -32512, 0, 0, 0);
    step(0, 127, 1, 1, 0,    0, 0, 0, -32768, 1, 0, 0);
    step(0,   0, 0, 0, 1,    0, 0, 0,      0, 0, 0, 0);
    // zero operands with w_act=2
    step(0,   0, 0, 0, 0,    2, 1, 0,      0, 0, 1, 0);
    step(0,   0, 0, 0, 0,    0, 0, 1,      0, 0, 0, 0);
    step(0,   0, 1, 1, 0,    0, 0, 0,      0, 0, 0, 0);
    step(0,   5, 1, 1, 0,    0, 0, 0,     10, 0, 0, 0);
    step(0,   0, 1, 1, 0,    0, 0, 0,     10, 0, 0, 0);

    @(negedge clk);
    a_vld_in = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    w_load   = 1'b0;
    w_swap   = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
`ifdef PE_ZERO_SKIP_EN
    chk("skip_cnt", 32'(skip_cnt), 2);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_ws_db.md
# pe_ws_db

Parametrised weight-stationary processing element with a double-buffered weight register, a valid-tagged activation path and a saturating accumulator with a sticky overflow flag. The next weight can be loaded into a shadow register while the active weight is in use, then promoted with a single-cycle swap, so compute does not stall between weight tiles. It is the tile cell of the systolic array: activations enter from the left neighbour and leave to the right, weights arrive from the top-edge loader, and the accumulator is read by the array drain logic.

## Interface
- `A_W`, 8: activation width, signed.
- `W_W`, 8: weight width, signed.
- `ACC_W`, 32: accumulator width, signed. Must be ≥ `A_W+W_W`.
- `PIPE`, 1: 1 = registered activation forward; 0 = combinational forward.
- `SAT`, 1: 1 = clamp the accumulator at signed `ACC_W` limits; 0 = two's-complement wrap.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `a_in` in `A_W`: activation from the left.
- `a_vld_in` in 1: `a_in` is valid.
- `a_out` out `A_W`: activation to the right.
- `a_vld_out` out 1: `a_out` is valid.
- `w_in` in `W_W`: weight data.
- `w_load` in 1: write `w_in` into the shadow register.
- `w_swap` in 1: promote the shadow register to the active weight.
- `en` in 1: MAC enable.
- `clr` in 1: accumulator clear / start of a new accumulation.
- `acc` out `ACC_W`: accumulator value.
- `shadow_vld` out 1: the shadow register holds an unconsumed weight.
- `sat_flag` out 1: sticky flag, set when the accumulator has saturated or wrapped since the last clear.
- `swap_err` out 1: sticky flag, set when a swap is requested while the shadow register is empty.

## Operation
- A MAC fires in any cycle where `mac = en & a_vld_in`. Its product is `a_in * w_act`, signed, `A_W+W_W` bits, sign-extended to `ACC_W`.
- Accumulator next value, in priority order:
  - `clr & mac`: the product (starts a new sum).
  - `clr`: 0.
  - `mac`: `acc` + product.
  - otherwise: hold.
- Saturation, when `SAT`=1: the sum is computed at `ACC_W+1` bits and clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- `sat_flag`:
  - With `SAT`=1, set on any clamp.
  - With `SAT`=0, set on any signed overflow.
  - Cleared by `clr`, unless that same `clr & mac` product itself clamps, in which case it is set.
- Weight buffering:
  - `w_load` writes `w_shadow <= w_in` and sets `shadow_vld`.
  - `w_swap` with `shadow_vld`=1 does `w_act <= w_shadow` and clears `shadow_vld`.
  - `w_swap` with `shadow_vld`=0 leaves `w_act` unchanged and sets `swap_err`. `swap_err` clears only on `rst`.
  - `w_load` and `w_swap` in the same cycle: `w_act` takes the old shadow value, the shadow takes `w_in`, and `shadow_vld` stays 1. If the shadow was empty, `swap_err` is set and the new load still takes effect.
  - A MAC in a swap cycle uses the old `w_act`. The new weight applies from the next cycle.
- Activation forward:
  - `PIPE`=1: `a_out` and `a_vld_out` are registered copies of `a_in` and `a_vld_in`.
  - `PIPE`=0: they are combinational copies.
  - Forwarding is independent of `en`.
- Reset values: `acc` 0, `w_act` 0, `w_shadow` 0, `shadow_vld` 0, `sat_flag` 0, `swap_err` 0. With `PIPE`=1, `a_out` 0 and `a_vld_out` 0.
- Reset asserted mid-accumulation discards all state on the next edge. Reset overrides every input.

## Timing
- MAC latency is 1: `acc` reflects a MAC issued in cycle N at cycle N+1.
- `clr` latency is 1.
- Weight path: `w_load` in cycle N, `w_swap` in cycle N+1, and the first MAC using the new weight is at N+2. Back-to-back loads overwrite the shadow; the last one wins.
- Activation forward latency is `PIPE` cycles.
- Flags update in the same edge as `acc`.
- No backpressure. The upstream loader must check `shadow_vld` before overwriting a weight it has not yet swapped in.

## Configuration
- Macro `PE_ZERO_SKIP_EN`.
- When defined:
  - If `a_in`==0 or `w_act`==0 during a MAC, the accumulator register enable is gated off, except on `clr` cycles.
  - An extra output, `skip_cnt` (16 bits, saturating at 0xFFFF, cleared by `rst` or `clr`), counts the skipped MACs.
  - The `acc` value is identical to the non-gated build.
- When undefined: no gating and no `skip_cnt` port.

## Structure
- Package `pe_pkg`:
  - Default width localparams.
  - A `sat_add` function parametrised by width.
  - A `pe_ctrl_t` struct packing `en`, `clr`, `w_load`, `w_swap`, used by the array controller.
- One sub-module, `pe_wbuf`: the shadow/active weight registers, `shadow_vld` and `swap_err`. The MAC and forward logic stay in the top module.

## Test plan
1. Load sequence: `w_load` 3, `w_swap`, then MACs on `a` = 1, 2, 4 with `en`=1 → `acc` = 3, 9, 21 on successive cycles, and `shadow_vld` returns to 0.
2. Overlapped load: with `w_act`=3, load 5 during a MAC on `a`=2, then swap during a MAC on `a`=2 → `acc` rises +6, +6, then +10 on the following MAC.
3. Saturation: `ACC_W`=16, `acc`=32760, MAC 127×127 → `acc`=32767 and `sat_flag`=1. A following `clr & mac` on 1×1 → `acc`=1 and `sat_flag`=0.
4. Swap on an empty shadow after reset → `swap_err`=1 and `w_act` stays 0. Simultaneous `w_load` 7 and `w_swap` → `shadow_vld`=1 holding 7, and `w_act` unchanged.
5. Pipeline: `PIPE`=1, `a_vld_in` toggling 1,0,1 with values 9,x,−4 → `a_out`/`a_vld_out` repeat them one cycle later. Reset asserted mid-stream → every output is 0 on the next edge.
6. With `PE_ZERO_SKIP_EN`: MACs on `a` = 0, 5, 0 with `w_act`=2 → `acc`=10 and `skip_cnt`=2.
